// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NDIG = 4;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_GAP
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // True when digit i and every digit above it are zero; digit 0 never is.
    function automatic logic lead_zero(input logic [15:0] w, input logic [1:0] i);
        logic z;
        case (i)
            2'd0:    z = 1'b0;
            2'd1:    z = (w[15:4] == 12'h000);
            2'd2:    z = (w[15:8] == 8'h00);
            default: z = (w[15:12] == 4'h0);
        endcase
        return z;
    endfunction

endpackage

// File: rtl/seg7_scan_controller_hex_to_seg.sv
// Combinational hex digit to active-low seven-segment decoder.
// Shared by all four digits through the scanner's nibble mux.
module hex_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg7_scan_controller.sv
// Four-digit common-anode display scanner with dwell, blanking gap
// and optional leading-zero blanking; all outputs registered.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int GAP   = 2,
    parameter int LZB   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        enable,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [1:0]    idx;
    logic [1:0]    idx_n;
    logic          enter;
    logic [15:0]   shadow;
    logic [15:0]   word;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic [6:0]    cur_seg;
    logic          blank;
    logic          last;
    logic          on;

    // A load on the entry edge must be visible to that entry.
    assign word  = load ? value : shadow;
    assign nib   = word[{idx_n, 2'b00} +: 4];
    assign blank = (LZB != 0) && lead_zero(word, idx_n);
    assign on    = enable && (state == ST_ON);

    hex_to_seg u_dec (
        .nib (nib),
        .seg (dec)
    );

    // Next-state, counter and digit index sequencing.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        enter   = 1'b0;
        if (!enable) begin
            state_n = ST_OFF;
            cnt_n   = '0;
            idx_n   = 2'd0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_n = ST_ON;
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                    enter   = 1'b1;
                end
                ST_ON: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_n = '0;
                        idx_n = idx + 2'd1;
                        if (GAP > 0) begin
                            state_n = ST_GAP;
                        end else begin
                            state_n = ST_ON;
                            enter   = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_n   = '0;
                        state_n = ST_ON;
                        enter   = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                end
            endcase
        end
    end

    // FSM state, phase counter and digit index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_OFF;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // Shadow value and the pattern frozen for the digit being driven.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= 16'h0000;
            cur_seg <= SEG_BLANK;
        end else begin
            if (load) begin
                shadow <= value;
            end
            if (enter) begin
                cur_seg <= blank ? SEG_BLANK : dec;
            end
        end
    end

    // Registered pin drivers; disabling blanks the display on the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anode      <= ANODE_OFF;
            seg        <= SEG_BLANK;
            digit_idx  <= 2'd0;
            last       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            anode      <= on ? ~(4'b0001 << idx) : ANODE_OFF;
            seg        <= on ? cur_seg : SEG_BLANK;
            digit_idx  <= enable ? idx : 2'd0;
            last       <= on && (idx == 2'd3) && (cnt == DWELL_LAST);
            frame_done <= enable && last;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with DWELL=4, GAP=1, LZB=1.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_seg7_scan_controller;

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SF = 7'b0001110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    seg7_scan_controller #(
        .DWELL (4),
        .GAP   (1),
        .LZB   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .enable     (enable),
        .anode      (anode),
        .seg        (seg),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] an, input logic [6:0] sg,
                       input logic [1:0] di, input logic fd);
        @(negedge clk);
        chk("anode", 16'(an ^ anode ^ an), 16'(an));
        chk("seg", 16'(seg), 16'(sg));
        chk("digit_idx", 16'(digit_idx), 16'(di));
        chk("frame_done", 16'(frame_done), 16'(fd));
    endtask

    task automatic on_digit(input int d, input logic [6:0] sg, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << d);
        for (int c = 0; c < n; c++) begin
            cyc(an, sg, 2'(d), 1'b0);
        end
    endtask

    task automatic gap_cyc(input int nd, input logic fd);
        cyc(4'b1111, B, 2'(nd), fd);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        on_digit(0, s0, 4);
        gap_cyc(1, 1'b0);
        on_digit(1, s1, 4);
        gap_cyc(2, 1'b0);
        on_digit(2, s2, 4);
        gap_cyc(3, 1'b0);
        on_digit(3, s3, 4);
        gap_cyc(0, 1'b1);
    endtask

    task automatic restart(input logic [15:0] v);
        enable = 1'b0;
        load   = 1'b1;
        value  = v;
        cyc(4'b1111, B, 2'd0, 1'b0);
        enable = 1'b1;
        load   = 1'b0;
        cyc(4'b1111, B, 2'd0, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        load   = 1'b1;
        value  = 16'h1234;
        repeat (3) cyc(4'b1111, B, 2'd0, 1'b0);

        rst_n = 1'b1;
        cyc(4'b1111, B, 2'd0, 1'b0);
        load = 1'b0;
        frame(S4, S3, S2, S1);
        frame(S4, S3, S2, S1);

        restart(16'h0070);
        frame(S0, S7, B, B);
        restart(16'h0000);
        frame(S0, B, B, B);
        restart(16'hA0B0);
        frame(S0, SB, S0, SA);

        restart(16'h1234);
        on_digit(0, S4, 4);
        gap_cyc(1, 1'b0);
        on_digit(1, S3, 2);
        value = 16'hFFFF;
        load  = 1'b1;
        on_digit(1, S3, 1);
        load  = 1'b0;
        on_digit(1, S3, 1);
        gap_cyc(2, 1'b0);
        on_digit(2, SF, 4);
        gap_cyc(3, 1'b0);
        on_digit(3, SF, 4);
        gap_cyc(0, 1'b1);

        restart(16'h1234);
        on_digit(0, S4, 4);
        gap_cyc(1, 1'b0);
        on_digit(1, S3, 4);
        gap_cyc(2, 1'b0);
        on_digit(2, S2, 2);
        restart(16'h1234);
        frame(S4, S3, S2, S1);

        restart(16'h1234);
        on_digit(0, S4, 4);
        rst_n = 1'b0;
        cyc(4'b1111, B, 2'd0, 1'b0);
        rst_n = 1'b1;
        cyc(4'b1111, B, 2'd0, 1'b0);
        frame(S0, B, B, B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
